// File: rtl/bascomp_pkg.sv
// Shared encodings for the basic-computer control path: common-bus sources and sequencer states.
// Pure definitions; no logic, latency or flow control.
package bascomp_pkg;

   typedef enum logic [2:0] {
      BUS_NONE = 3'd0,
      BUS_AR   = 3'd1,
      BUS_PC   = 3'd2,
      BUS_DR   = 3'd3,
      BUS_AC   = 3'd4,
      BUS_IR   = 3'd5,
      BUS_TR   = 3'd6,
      BUS_MEM  = 3'd7
   } bus_sel_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_INIT = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam logic [3:0] SC_EXEC_FIRST = 4'd3;
   localparam logic [3:0] SC_LAST       = 4'd15;

endpackage

// File: rtl/seq_counter.sv
// 4-bit sequence counter: clear beats increment; value changes one cycle after the request.
// No flow control; async active-high reset to zero.
module seq_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] q
);

   logic [3:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 4'd0;
      end else if (clr) begin
         r_cnt <= 4'd0;
      end else if (inc) begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   assign q = r_cnt;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode timing sequencer: IDLE -> INIT -> RUN with T0..T15 slots.
// Strobes decode state/sc combinationally (zero latency); stop/exec_done act only at boundaries.
module fetch_sequencer
   import bascomp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] ir_in,
   input  logic        exec_done,
   output logic        pc_clr,
   output logic        pc_inc,
   output logic        ar_load,
   output logic        ir_load,
   output logic        mem_read,
   output logic [2:0]  bus_sel,
   output logic [15:0] t,
   output logic [7:0]  d,
   output logic        i_flag,
   output logic        running,
   output logic        timeout_err
);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [7:0] r_d;
   logic       r_i_flag;
   logic       r_timeout_err;
   logic [3:0] w_sc;
   logic       w_in_run;
   logic       w_boundary;
   logic       w_timeout;
   logic       w_sc_clr;
   logic       w_sc_inc;
   logic       w_unused_addr;

   assign w_unused_addr = ^ir_in[11:0];

   assign w_in_run   = (r_state == ST_RUN);
   assign w_timeout  = w_in_run && (w_sc == SC_LAST) && !exec_done;
   // An instruction ends on exec_done from T3 onward, or unconditionally after T15.
   assign w_boundary = w_in_run && (((w_sc >= SC_EXEC_FIRST) && exec_done) || (w_sc == SC_LAST));
   assign w_sc_clr   = !w_in_run || w_boundary;
   assign w_sc_inc   = w_in_run && !w_boundary;

   seq_counter u_sc (
      .clk (clk),
      .rst (rst),
      .inc (w_sc_inc),
      .clr (w_sc_clr),
      .q   (w_sc)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_nxt = ST_INIT;
         ST_INIT: w_state_nxt = ST_RUN;
         ST_RUN:  if (w_boundary && stop) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_d           <= 8'd0;
         r_i_flag      <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_in_run && (w_sc == 4'd2)) begin
            r_d      <= 8'd1 << ir_in[14:12];
            r_i_flag <= ir_in[15];
         end
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   always_comb begin
      pc_clr   = (r_state == ST_INIT);
      pc_inc   = 1'b0;
      ar_load  = 1'b0;
      ir_load  = 1'b0;
      mem_read = 1'b0;
      bus_sel  = BUS_NONE;
      if (w_in_run) begin
         case (w_sc)
            4'd0: begin
               bus_sel = BUS_PC;
               ar_load = 1'b1;
            end
            4'd1: begin
               bus_sel  = BUS_MEM;
               mem_read = 1'b1;
               ir_load  = 1'b1;
               pc_inc   = 1'b1;
            end
            4'd2: begin
               bus_sel = BUS_IR;
               ar_load = 1'b1;
            end
            default: bus_sel = BUS_NONE;
         endcase
      end
   end

   assign t           = w_in_run ? (16'd1 << w_sc) : 16'd0;
   assign running     = (r_state != ST_IDLE);
   assign d           = r_d;
   assign i_flag      = r_i_flag;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written corner sequences, random run vs model.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic [15:0] ir_in;
   logic        exec_done;
   logic        pc_clr, pc_inc, ar_load, ir_load, mem_read;
   logic [2:0]  bus_sel;
   logic [15:0] t;
   logic [7:0]  d;
   logic        i_flag, running, timeout_err;

   int total = 0;
   int bad   = 0;

   fetch_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .ir_in       (ir_in),
      .exec_done   (exec_done),
      .pc_clr      (pc_clr),
      .pc_inc      (pc_inc),
      .ar_load     (ar_load),
      .ir_load     (ir_load),
      .mem_read    (mem_read),
      .bus_sel     (bus_sel),
      .t           (t),
      .d           (d),
      .i_flag      (i_flag),
      .running     (running),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        sp;
      logic        ed;
      logic [15:0] et;
      logic [2:0]  ebus;
      logic [4:0]  estrb;
      logic        erun;
      logic [7:0]  ed8;
      logic        ei;
   } vec_t;

   vec_t vecs[16];

   // Reference model: phase 0=idle 1=init 2=run, step = position within the instruction.
   int         m_phase;
   int         m_step;
   logic [7:0] m_d;
   logic       m_i;
   logic       m_terr;

   // {t, d, bus_sel, pc_clr, pc_inc, ar_load, ir_load, mem_read, i_flag, running, timeout_err}
   function automatic logic [34:0] obs();
      return {t, d, bus_sel, pc_clr, pc_inc, ar_load, ir_load, mem_read, i_flag, running, timeout_err};
   endfunction

   task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_step  = 0;
      m_d     = 8'd0;
      m_i     = 1'b0;
      m_terr  = 1'b0;
   endtask

   task automatic model_step(input logic st, input logic sp, input logic ed, input logic [15:0] ir);
      if (m_phase == 0) begin
         if (st) m_phase = 1;
      end else if (m_phase == 1) begin
         m_phase = 2;
         m_step  = 0;
      end else begin
         if (m_step == 2) begin
            m_d = 8'd1 << ir[14:12];
            m_i = ir[15];
         end
         if ((m_step >= 3 && ed) || m_step == 15) begin
            if (m_step == 15 && !ed) m_terr = 1'b1;
            m_step = 0;
            if (sp) m_phase = 0;
         end else begin
            m_step = m_step + 1;
         end
      end
   endtask

   function automatic logic [34:0] model_exp();
      logic [15:0] et;
      logic [2:0]  eb;
      logic [4:0]  es;
      et = 16'd0;
      eb = 3'd0;
      es = 5'b00000;
      if (m_phase == 1) es = 5'b10000;
      if (m_phase == 2) begin
         et = 16'd1 << m_step;
         if (m_step == 0) begin eb = 3'd2; es = 5'b00100; end
         if (m_step == 1) begin eb = 3'd7; es = 5'b01011; end
         if (m_step == 2) begin eb = 3'd5; es = 5'b00100; end
      end
      return {et, m_d, eb, es, m_i, (m_phase != 0), m_terr};
   endfunction

   // Called at a negedge; applies inputs across one rising edge and returns at the next negedge.
   task automatic cycle(input logic st, input logic sp, input logic ed, input logic [15:0] ir);
      start     = st;
      stop      = sp;
      exec_done = ed;
      ir_in     = ir;
      @(posedge clk);
      model_step(st, sp, ed, ir);
      @(negedge clk);
   endtask

   initial begin
      logic r, st, sp, ed;
      logic [15:0] ir;

      rst = 1'b1; start = 1'b0; stop = 1'b0; exec_done = 1'b0; ir_in = 16'hA123;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_state", obs(), 35'd0);
      rst = 1'b0;

      //          st    sp    ed    t         bus   strobes   run   d      i
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 5'b10000, 1'b1, 8'h00, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 3'd2, 5'b00100, 1'b1, 8'h00, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 3'd7, 5'b01011, 1'b1, 8'h00, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 3'd5, 5'b00100, 1'b1, 8'h00, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0008, 3'd0, 5'b00000, 1'b1, 8'h04, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0010, 3'd0, 5'b00000, 1'b1, 8'h04, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 3'd2, 5'b00100, 1'b1, 8'h04, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0002, 3'd7, 5'b01011, 1'b1, 8'h04, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0004, 3'd5, 5'b00100, 1'b1, 8'h04, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0008, 3'd0, 5'b00000, 1'b1, 8'h04, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0010, 3'd0, 5'b00000, 1'b1, 8'h04, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0020, 3'd0, 5'b00000, 1'b1, 8'h04, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 16'h0000, 3'd0, 5'b00000, 1'b0, 8'h04, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 5'b10000, 1'b1, 8'h04, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 16'h0001, 3'd2, 5'b00100, 1'b1, 8'h04, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h0002, 3'd7, 5'b01011, 1'b1, 8'h04, 1'b1};

      for (int k = 0; k < 16; k++) begin
         cycle(vecs[k].st, vecs[k].sp, vecs[k].ed, 16'hA123);
         check($sformatf("vec%0d", k), obs(),
               {vecs[k].et, vecs[k].ed8, vecs[k].ebus, vecs[k].estrb, vecs[k].ei, vecs[k].erun, 1'b0});
      end

      // Timeout: from T1, fourteen cycles reach T15 with no error yet, then the wrap raises it.
      for (int k = 0; k < 14; k++) cycle(1'b0, 1'b0, 1'b0, 16'hA123);
      check1("at_t15", {t, 15'd0, timeout_err}, {16'h8000, 15'd0, 1'b0});
      cycle(1'b0, 1'b0, 1'b0, 16'h3456);
      check1("wrap_t0", {t, 15'd0, timeout_err}, {16'h0001, 15'd0, 1'b1});
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 16'h3456);
      check1("terr_sticky", {t, d, i_flag, 6'd0, timeout_err}, {16'h0008, 8'h08, 1'b0, 6'd0, 1'b1});

      // Reset mid-fetch: strobes must drop without waiting for a clock edge.
      cycle(1'b0, 1'b0, 1'b1, 16'h3456);
      cycle(1'b0, 1'b0, 1'b0, 16'h3456);
      check1("pre_rst_t1", {29'd0, ir_load, pc_inc, mem_read}, 32'd7);
      #2 rst = 1'b1;
      #1 check("async_rst", obs(), 35'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1, 16'h3456);
      check("idle_after_rst", obs(), 35'd0);
      cycle(1'b1, 1'b0, 1'b0, 16'h3456);
      check("restart", obs(), model_exp());

      // Randomized run against the model, with occasional resets.
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         r  = ($urandom_range(0, 299) == 0);
         st = ($urandom_range(0, 3) == 0);
         sp = ($urandom_range(0, 2) == 0);
         ed = ($urandom_range(0, 9) == 0);
         ir = 16'($urandom);
         rst = r;
         if (r) model_reset();
         start = st; stop = sp; exec_done = ed; ir_in = ir;
         @(posedge clk);
         if (!r) model_step(st, sp, ed, ir);
         @(negedge clk);
         check($sformatf("rand%0d", n), obs(), model_exp());
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
